// File: rtl/yutorina_gpr_pkg.sv
// Shared definitions for the Yutorina multi-context register file.
// Holds the default sizes, the hardwired-zero register address and the
// copy-engine state encoding.
package yutorina_gpr_pkg;
   localparam int GPR_DATA_W = 32;
   localparam int GPR_ADDR_W = 5;
   localparam int GPR_CTX_W  = 2;
   localparam int GPR_ZERO   = 0;

   typedef enum logic [1:0] {
      CP_IDLE = 2'd0,
      CP_COPY = 2'd1,
      CP_DONE = 2'd2
   } cp_state_e;
endpackage

// File: rtl/yutorina_gpr_copy_fsm.sv
// Background bank-copy sequencer.
// Ports: clk/rst (sync, active-high); cp_req/cp_src/cp_dst request inputs
// (sampled in IDLE only); cp_busy/cp_done/cp_err status; cp_we/cp_idx/
// src/dst tell the storage which register to copy this cycle.
module yutorina_gpr_copy_fsm
   import yutorina_gpr_pkg::*;
#(
   parameter int ADDR_W = GPR_ADDR_W,
   parameter int CTX_W  = GPR_CTX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cp_req,
   input  logic [CTX_W-1:0]  cp_src,
   input  logic [CTX_W-1:0]  cp_dst,
   output logic              cp_busy,
   output logic              cp_done,
   output logic              cp_err,
   output logic              cp_we,
   output logic [ADDR_W-1:0] cp_idx,
   output logic [CTX_W-1:0]  src,
   output logic [CTX_W-1:0]  dst
);
   localparam logic [ADDR_W-1:0] IDX_LAST = '1;

   cp_state_e         state_q, state_d;
   logic [CTX_W-1:0]  src_q, src_d, dst_q, dst_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              err_q, err_d;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      idx_d   = idx_q;
      err_d   = 1'b0;
      case (state_q)
         CP_IDLE: begin
            if (cp_req) begin
               if (cp_src == cp_dst) begin
                  err_d = 1'b1;
               end else begin
                  src_d   = cp_src;
                  dst_d   = cp_dst;
                  // register 0 is never copied, start at 1
                  idx_d   = ADDR_W'(1);
                  state_d = CP_COPY;
               end
            end
         end
         CP_COPY: begin
            // idx holds at the last register; it never wraps back to 0
            if (idx_q == IDX_LAST) state_d = CP_DONE;
            else                   idx_d   = idx_q + 1'b1;
         end
         CP_DONE: state_d = CP_IDLE;
         default: state_d = CP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CP_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   assign cp_busy = (state_q != CP_IDLE);
   assign cp_done = (state_q == CP_DONE);
   assign cp_err  = err_q;
   assign cp_we   = (state_q == CP_COPY);
   assign cp_idx  = idx_q;
   assign src     = src_q;
   assign dst     = dst_q;
endmodule

// File: rtl/yutorina_gpr_ctx.sv
// Multi-context GPR file: 2^CTX_W banks of 2^ADDR_W registers, RD_PORTS
// combinational read ports with write bypass, one write port (we_ active-low),
// and a background copy engine that keeps the destination bank coherent with
// live writes to the source bank.
// Ports: clk/rst; ctx selects the bank for all user ports; r_addr/r_data
// packed read ports; we_/w_addr/w_data write port; cp_* copy control/status;
// wr_drop pulses when a write to the copy destination was discarded.
module yutorina_gpr_ctx
   import yutorina_gpr_pkg::*;
#(
   parameter int DATA_W   = GPR_DATA_W,
   parameter int ADDR_W   = GPR_ADDR_W,
   parameter int CTX_W    = GPR_CTX_W,
   parameter int RD_PORTS = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CTX_W-1:0]           ctx,
   input  logic [RD_PORTS*ADDR_W-1:0] r_addr,
   output logic [RD_PORTS*DATA_W-1:0] r_data,
   input  logic                       we_,
   input  logic [ADDR_W-1:0]          w_addr,
   input  logic [DATA_W-1:0]          w_data,
   input  logic                       cp_req,
   input  logic [CTX_W-1:0]           cp_src,
   input  logic [CTX_W-1:0]           cp_dst,
   output logic                       cp_busy,
   output logic                       cp_done,
   output logic                       cp_err,
   output logic                       wr_drop
);
   localparam int CTX_NUM = 1 << CTX_W;
   localparam int NUM     = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [CTX_NUM][NUM];
   logic [DATA_W-1:0] mem_d [CTX_NUM][NUM];
   logic              wr_drop_q, wr_drop_d;

   logic              cp_we;
   logic [ADDR_W-1:0] cp_idx;
   logic [CTX_W-1:0]  src, dst;

   logic              wr_en, drop, user_wr, mirror, src_byp;
   logic [DATA_W-1:0] cp_val;

   yutorina_gpr_copy_fsm #(.ADDR_W(ADDR_W), .CTX_W(CTX_W)) u_fsm (
      .clk     (clk),
      .rst     (rst),
      .cp_req  (cp_req),
      .cp_src  (cp_src),
      .cp_dst  (cp_dst),
      .cp_busy (cp_busy),
      .cp_done (cp_done),
      .cp_err  (cp_err),
      .cp_we   (cp_we),
      .cp_idx  (cp_idx),
      .src     (src),
      .dst     (dst)
   );

   assign wr_en   = !we_ && (w_addr != ADDR_W'(GPR_ZERO));
   // dst is owned by the copy engine while copying; user writes there are lost
   assign drop    = wr_en && cp_we && (ctx == dst);
   assign user_wr = wr_en && !drop;
   // source registers already copied must be mirrored into dst
   assign mirror  = user_wr && cp_we && (ctx == src) && (w_addr < cp_idx);
   // same-cycle write to the register being copied wins over storage
   assign src_byp = user_wr && (ctx == src) && (w_addr == cp_idx);
   assign cp_val  = src_byp ? w_data : mem_q[src][cp_idx];

   // src != dst, so the user write, mirror and copy never hit the same entry
   always_comb begin
      mem_d = mem_q;
      if (user_wr) mem_d[ctx][w_addr] = w_data;
      if (mirror)  mem_d[dst][w_addr] = w_data;
      if (cp_we && (cp_idx != ADDR_W'(GPR_ZERO))) mem_d[dst][cp_idx] = cp_val;
      wr_drop_d = drop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CTX_NUM; c++)
            for (int a = 0; a < NUM; a++)
               mem_q[c][a] <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   assign wr_drop = wr_drop_q;

   for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = r_addr[p*ADDR_W +: ADDR_W];
      assign r_data[p*DATA_W +: DATA_W] =
         (user_wr && (w_addr == ra)) ? w_data : mem_q[ctx][ra];
   end
endmodule

// File: tb/tb_yutorina_gpr_ctx.sv
// Bench for yutorina_gpr_ctx: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a bank-array model.
module tb_yutorina_gpr_ctx;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ctx;
   logic [9:0]  r_addr;
   logic [63:0] r_data;
   logic        we_;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic        cp_req;
   logic [1:0]  cp_src, cp_dst;
   logic        cp_busy, cp_done, cp_err, wr_drop;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   yutorina_gpr_ctx #(.DATA_W(32), .ADDR_W(5), .CTX_W(2), .RD_PORTS(2)) dut (
      .clk(clk), .rst(rst), .ctx(ctx), .r_addr(r_addr), .r_data(r_data),
      .we_(we_), .w_addr(w_addr), .w_data(w_data), .cp_req(cp_req),
      .cp_src(cp_src), .cp_dst(cp_dst), .cp_busy(cp_busy), .cp_done(cp_done),
      .cp_err(cp_err), .wr_drop(wr_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: banks as a plain array; copy progress as pos
   // (0 = idle, 1..31 = copying register pos, 32 = done cycle).
   logic [31:0] m [4][32];
   int          pos = 0;
   logic [1:0]  ms, md;
   logic        e_err = 0, e_drop = 0;

   always @(posedge clk) begin : mdl
      logic wr, cpy, dr;
      logic [31:0] v;
      if (rst) begin
         for (int c = 0; c < 4; c++)
            for (int a = 0; a < 32; a++) m[c][a] = 0;
         pos = 0; e_err = 0; e_drop = 0;
      end else begin
         wr  = !we_ && w_addr != 0;
         cpy = pos >= 1 && pos <= 31;
         dr  = wr && cpy && ctx == md;
         v   = 0;
         if (cpy) v = (wr && ctx == ms && int'(w_addr) == pos) ? w_data : m[ms][pos];
         if (wr && !dr) begin
            m[ctx][w_addr] = w_data;
            if (cpy && ctx == ms && int'(w_addr) < pos) m[md][w_addr] = w_data;
         end
         if (cpy) m[md][pos] = v;
         e_err  = (pos == 0 && cp_req && cp_src == cp_dst);
         e_drop = dr;
         if (pos == 0) begin
            if (cp_req && cp_src != cp_dst) begin
               pos = 1; ms = cp_src; md = cp_dst;
            end
         end else if (pos == 32) pos = 0;
         else pos++;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin : cmp
      logic wr, dr;
      logic [4:0] a;
      logic [31:0] e;
      if (chk_en) begin
         chk("busy", cp_busy, pos != 0);
         chk("done", cp_done, pos == 32);
         chk("err", cp_err, e_err);
         chk("drop", wr_drop, e_drop);
         wr = !we_ && w_addr != 0;
         dr = wr && pos >= 1 && pos <= 31 && ctx == md;
         for (int p = 0; p < 2; p++) begin
            a = r_addr[p*5 +: 5];
            e = (wr && !dr && w_addr == a) ? w_data : m[ctx][a];
            chk(p == 0 ? "rdata0" : "rdata1", r_data[p*32 +: 32], e);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int c, input int a, input logic [31:0] e, input string nm);
      ctx = 2'(c); r_addr = {5'(31 - a), 5'(a)}; we_ = 1; cp_req = 0;
      #2;
      chk(nm, r_data[31:0], e);
      cyc();
   endtask

   task automatic wait_done(input string nm, output int n);
      n = 0;
      while (cp_done !== 1'b1 && n < 100) begin
         cyc(); #2; n++;
      end
      chk(nm, {31'b0, cp_done}, 1);
   endtask

   int n;

   initial begin
      rst = 1; we_ = 1; cp_req = 0; ctx = 0; r_addr = 0; w_addr = 0;
      w_data = 0; cp_src = 0; cp_dst = 0;
      cyc(); cyc();
      rst = 0; chk_en = 1;

      // all banks zero on both ports
      for (int c = 0; c < 4; c++)
         for (int a = 0; a < 32; a++) begin
            ctx = 2'(c); r_addr = {5'(31 - a), 5'(a)};
            #2;
            chk("rst_p0", r_data[31:0], 0);
            chk("rst_p1", r_data[63:32], 0);
            cyc();
         end

      // same-cycle bypass, then storage, then bank isolation
      ctx = 1; we_ = 0; w_addr = 5; w_data = 32'hDEAD_BEEF; r_addr = 10'd5;
      #2; chk("bypass", r_data[31:0], 32'hDEAD_BEEF);
      cyc();
      rd(2, 5, 0, "ctx2_r5");
      rd(1, 5, 32'hDEAD_BEEF, "ctx1_r5");

      // r0 ignores writes and never bypasses
      ctx = 1; we_ = 0; w_addr = 0; w_data = 32'hFFFF_FFFF; r_addr = 0;
      #2; chk("r0_byp0", r_data[31:0], 0); chk("r0_byp1", r_data[63:32], 0);
      cyc();
      rd(1, 0, 0, "r0_store");

      // fill ctx0 with i*3 and copy to ctx3
      ctx = 0; we_ = 0;
      for (int i = 1; i < 32; i++) begin
         w_addr = 5'(i); w_data = 32'(i * 3); cyc();
      end
      we_ = 1;
      cp_src = 0; cp_dst = 3; cp_req = 1;
      #2; chk("busy_t", {31'b0, cp_busy}, 0);
      cyc(); cp_req = 0;
      #2; chk("busy_t1", {31'b0, cp_busy}, 1);
      wait_done("cp1_done", n);
      chk("cp1_lat", n + 1, 32);
      cyc(); #2;
      chk("idle_busy", {31'b0, cp_busy}, 0);
      chk("idle_done", {31'b0, cp_done}, 0);
      cyc();
      for (int i = 0; i < 32; i++) rd(3, i, 32'(i * 3), "cp1_data");

      // copy with live writes: bypass at idx10, mirror, later copy, drop
      cp_src = 0; cp_dst = 3; cp_req = 1; cyc(); cp_req = 0;
      repeat (9) cyc();
      ctx = 0; we_ = 0; w_addr = 10; w_data = 32'h5678; cyc();
      w_addr = 4;  w_data = 32'h1234; cyc();
      w_addr = 20; w_data = 32'h9ABC; cyc();
      ctx = 3; w_addr = 7; w_data = 32'hAAAA; r_addr = 10'd7;
      #2; chk("drop_nobyp", r_data[31:0], 21);
      cyc(); we_ = 1; ctx = 0;
      #2; chk("drop_pulse", {31'b0, wr_drop}, 1);
      cyc(); #2; chk("drop_off", {31'b0, wr_drop}, 0);
      wait_done("cp2_done", n);
      cyc();
      rd(3, 4, 32'h1234, "mirror");
      rd(3, 10, 32'h5678, "cp_byp");
      rd(3, 20, 32'h9ABC, "later");
      rd(3, 7, 21, "dropped");
      rd(0, 20, 32'h9ABC, "src_r20");

      // src == dst is rejected
      cp_src = 1; cp_dst = 1; cp_req = 1; cyc(); cp_req = 0;
      #2; chk("err_pulse", {31'b0, cp_err}, 1); chk("err_busy", {31'b0, cp_busy}, 0);
      cyc(); #2; chk("err_off", {31'b0, cp_err}, 0);
      cyc();

      // reset at idx 15 aborts
      cp_src = 0; cp_dst = 3; cp_req = 1; cyc(); cp_req = 0;
      repeat (14) cyc();
      rst = 1; cyc(); rst = 0;
      #2; chk("abort_busy", {31'b0, cp_busy}, 0); chk("abort_done", {31'b0, cp_done}, 0);
      cyc();
      rd(0, 3, 0, "abort_c0"); rd(3, 3, 0, "abort_c3"); rd(1, 5, 0, "abort_c1");
      repeat (20) cyc();
      ctx = 2; we_ = 0; w_addr = 9; w_data = 77; cyc(); we_ = 1;
      cp_src = 2; cp_dst = 1; cp_req = 1; cyc(); cp_req = 0;
      wait_done("cp3_done", n);
      cyc();
      rd(1, 9, 77, "cp3_r9"); rd(1, 8, 0, "cp3_r8");

      // randomized traffic
      repeat (3000) begin
         rst    = ($urandom_range(0, 399) == 0);
         ctx    = 2'($urandom);
         r_addr = 10'($urandom);
         we_    = 1'($urandom);
         w_addr = 5'($urandom);
         w_data = $urandom;
         cp_req = ($urandom_range(0, 15) == 0);
         cp_src = 2'($urandom);
         cp_dst = 2'($urandom);
         cyc();
      end
      rst = 0; we_ = 1; cp_req = 0;
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
